// File: rtl/lsu_dmem.sv
// rtl/lsu_dmem.sv - load/store unit with byte-addressed data memory; word-spanning accesses split over two cycles
// Define LSU_MISALIGN_TRAP_EN to flag spanning accesses on MisalignErr instead of splitting them.
module lsu_dmem #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  DataSrc,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        MisalignErr
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic {ST_IDLE = 1'b0, ST_SECOND = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [31:0]       hold_q, hold_d;
   logic [31:0]       mem [DEPTH_WORDS];

   logic [1:0]        off;
   logic [4:0]        sh_amt;
   logic [1:0]        size;
   logic [IDX_W-1:0]  idx, idx_n;
   logic              is_load, is_store, ld_ok, st_ok, spanning, trap;
   logic [3:0]        be4;
   logic [7:0]        be64;
   logic [63:0]       wd64;
   logic [31:0]       word_n, word_n1, hi_part, raw, ext;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [3:0]        wr_be;
   logic [31:0]       wr_data;
   logic              unused_addr;

   assign unused_addr = ^ALUResult[31:IDX_W+2];

   always_comb begin
      off      = ALUResult[1:0];
      sh_amt   = {off, 3'b000};
      size     = DataSrc[1:0];
      idx      = ALUResult[IDX_W+1:2];
      idx_n    = idx + 1'b1;
      is_store = MemWrite;
      is_load  = MemRead && !MemWrite;
      ld_ok    = is_load && (DataSrc[1:0] != 2'b11) && (DataSrc[2:1] != 2'b11);
      st_ok    = is_store && !DataSrc[2] && (DataSrc[1:0] != 2'b11);
      spanning = (ld_ok || st_ok) &&
                 (((size == 2'b01) && (off == 2'b11)) || ((size == 2'b10) && (off != 2'b00)));
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = spanning;
`else
   assign trap = 1'b0;
`endif

   // Store lanes laid out across a two-word window: low nibble is word N, high nibble word N+1.
   always_comb begin
      case (size)
         2'b00:   be4 = 4'b0001;
         2'b01:   be4 = 4'b0011;
         default: be4 = 4'b1111;
      endcase
      be64 = {4'b0000, be4} << off;
      wd64 = {32'b0, WriteData} << sh_amt;
   end

   always_comb begin
      word_n  = mem[idx];
      word_n1 = mem[idx_n];
      hi_part = word_n1 << (6'd32 - {1'b0, sh_amt});
      if (state_q == ST_SECOND) raw = hold_q | hi_part;
      else                      raw = word_n >> sh_amt;
      case (DataSrc)
         3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
         3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
         3'b100:  ext = {24'b0, raw[7:0]};
         3'b101:  ext = {16'b0, raw[15:0]};
         default: ext = raw;
      endcase
   end

   always_comb begin
      ReadData    = '0;
      Stall       = 1'b0;
      MisalignErr = 1'b0;
      if (Reset) begin
         MisalignErr = trap;
         Stall       = (state_q == ST_IDLE) && spanning && !trap;
         if (ld_ok && !((state_q == ST_IDLE) && spanning)) ReadData = ext;
      end
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = idx;
      wr_be   = 4'b0000;
      wr_data = wd64[31:0];
      if (Reset && st_ok && !trap) begin
         wr_en = 1'b1;
         if (state_q == ST_IDLE) begin
            wr_be = be64[3:0];
         end else begin
            wr_idx  = idx_n;
            wr_be   = be64[7:4];
            wr_data = wd64[63:32];
         end
      end
   end

   // hold_q keeps word N already shifted down, so SECOND only ORs in the word N+1 bytes.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (state_q == ST_IDLE) begin
         if (spanning && !trap) begin
            state_d = ST_SECOND;
            if (ld_ok) hold_d = word_n >> sh_amt;
         end
      end else begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_lsu_dmem.sv
// tb/tb_lsu_dmem.sv - scoreboard bench for lsu_dmem
// Honours LSU_MISALIGN_TRAP_EN for the misaligned-access section.
module tb_lsu_dmem;

   logic        clk = 1'b0;
   logic        Reset;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  DataSrc;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Stall;
   logic        MisalignErr;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

   typedef struct {
      logic [31:0] rd;
      logic        stall;
      logic        merr;
      bit          chk_rd;
   } exp_t;

   exp_t sb_q[$];

   lsu_dmem #(.DEPTH_WORDS(256)) dut (
      .clk        (clk),
      .Reset      (Reset),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .DataSrc    (DataSrc),
      .ALUResult  (ALUResult),
      .WriteData  (WriteData),
      .ReadData   (ReadData),
      .Stall      (Stall),
      .MisalignErr(MisalignErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input bit rst, input bit rd, input bit wr,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input bit estall, input bit emerr);
      exp_t e;
      Reset     = rst;
      MemRead   = rd;
      MemWrite  = wr;
      DataSrc   = f3;
      ALUResult = addr;
      WriteData = wd;
      e.rd     = erd;
      e.stall  = estall;
      e.merr   = emerr;
      e.chk_rd = !estall && (rd || !wr);
      sb_q.push_back(e);
      @(negedge clk);
      e = sb_q.pop_front();
      chk({tag, ".stall"}, {31'b0, Stall}, {31'b0, e.stall});
      chk({tag, ".merr"}, {31'b0, MisalignErr}, {31'b0, e.merr});
      if (e.chk_rd) chk({tag, ".rd"}, ReadData, e.rd);
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] erd);
      step(tag, 1'b1, 1'b1, 1'b0, f3, addr, 32'h0, erd, 1'b0, 1'b0);
   endtask

   task automatic st(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd);
      step(tag, 1'b1, 1'b0, 1'b1, f3, addr, wd, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      Reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      DataSrc = 3'b0; ALUResult = 32'h0; WriteData = 32'h0;
      @(posedge clk);
      #1;

      step("rst", 1'b0, 1'b1, 1'b0, LW, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      st("pre0", LW, 32'h0, 32'h1122_3344);
      ld("lw0", LW, 32'h0, 32'h1122_3344);

      st("sw10", LW, 32'h10, 32'h8000_0083);
      ld("lb10", LB, 32'h10, 32'hFFFF_FF83);
      ld("lbu10", LBU, 32'h10, 32'h0000_0083);
      ld("lh12", LH, 32'h12, 32'hFFFF_8000);
      ld("lhu12", LHU, 32'h12, 32'h0000_8000);

      st("sb13", LB, 32'h13, 32'h1234_56AB);
      ld("lw10", LW, 32'h10, 32'hAB00_0083);

      ld("rsvld011", 3'b011, 32'h10, 32'h0);
      ld("rsvld110", 3'b110, 32'h11, 32'h0);
      st("rsvst011", 3'b011, 32'h10, 32'hFFFF_FFFF);
      st("rsvst110", 3'b110, 32'h11, 32'hFFFF_FFFF);
      ld("lw10b", LW, 32'h10, 32'hAB00_0083);

      step("rdwr", 1'b1, 1'b1, 1'b1, LW, 32'h30, 32'h0000_0055, 32'h0, 1'b0, 1'b0);
      ld("lw30", LW, 32'h30, 32'h0000_0055);
      step("idle", 1'b1, 1'b0, 1'b0, LW, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
      st("pre4", LW, 32'h04, 32'h7766_5544);
      step("trap_lh03", 1'b1, 1'b1, 1'b0, LH, 32'h03, 32'h0, 32'h0, 1'b0, 1'b1);
      step("trap_sh03", 1'b1, 1'b0, 1'b1, LH, 32'h03, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
      step("trap_lw3fd", 1'b1, 1'b1, 1'b0, LW, 32'h3FD, 32'h0, 32'h0, 1'b0, 1'b1);
      ld("trap_lw0", LW, 32'h0, 32'h1122_3344);
      ld("trap_lw4", LW, 32'h04, 32'h7766_5544);
`else
      st("pre0c", LW, 32'h0C, 32'h4433_2211);
      st("pre10", LW, 32'h10, 32'h8877_6655);
      for (int r = 0; r < 2; r++) begin
         step($sformatf("lw0e_%0d_a", r), 1'b1, 1'b1, 1'b0, LW, 32'h0E, 32'h0, 32'h0, 1'b1, 1'b0);
         step($sformatf("lw0e_%0d_b", r), 1'b1, 1'b1, 1'b0, LW, 32'h0E, 32'h0, 32'h6655_4433, 1'b0, 1'b0);
      end
      step("lh0f_a", 1'b1, 1'b1, 1'b0, LH, 32'h0F, 32'h0, 32'h0, 1'b1, 1'b0);
      step("lh0f_b", 1'b1, 1'b1, 1'b0, LH, 32'h0F, 32'h0, 32'h0000_5544, 1'b0, 1'b0);
      ld("lh0d", LH, 32'h0D, 32'h0000_3322);

      st("pre3fc", LW, 32'h3FC, 32'hA1B2_C3C4);
      step("sw3fd_a", 1'b1, 1'b0, 1'b1, LW, 32'h3FD, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
      step("sw3fd_b", 1'b1, 1'b0, 1'b1, LW, 32'h3FD, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
      ld("lw3fc", LW, 32'h3FC, 32'hADBE_EFC4);
      ld("lbu0wrap", LBU, 32'h0, 32'h0000_00DE);
      ld("lw0wrap", LW, 32'h0, 32'h1122_33DE);

      st("pre20", LW, 32'h20, 32'h0);
      st("pre24", LW, 32'h24, 32'h0102_0304);
      step("sw21_a", 1'b1, 1'b0, 1'b1, LW, 32'h21, 32'hCAFE_BABE, 32'h0, 1'b1, 1'b0);
      step("sw21_rst", 1'b0, 1'b0, 1'b1, LW, 32'h21, 32'hCAFE_BABE, 32'h0, 1'b0, 1'b0);
      ld("lw24", LW, 32'h24, 32'h0102_0304);
      ld("lw20", LW, 32'h20, 32'hFEBA_BE00);
      step("post_a", 1'b1, 1'b1, 1'b0, LW, 32'h0E, 32'h0, 32'h0, 1'b1, 1'b0);
      step("post_b", 1'b1, 1'b1, 1'b0, LW, 32'h0E, 32'h0, 32'h6655_4433, 1'b0, 1'b0);

      st("pre4", LW, 32'h04, 32'h7766_5544);
      step("lh03_a", 1'b1, 1'b1, 1'b0, LH, 32'h03, 32'h0, 32'h0, 1'b1, 1'b0);
      step("lh03_b", 1'b1, 1'b1, 1'b0, LH, 32'h03, 32'h0, 32'h0000_4411, 1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
